// File: rtl/wb_retire_monitor.sv
// Writeback-stage retire monitor: classifies each retired instruction, keeps
// saturating per-class/total/cycle counters and a show-ahead trace FIFO.
module wb_retire_monitor #(
  parameter int CW          = 32,
  parameter int DEPTH       = 8,
  parameter int CYCLE_LIMIT = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     clr,
  input  logic                     wb_valid,
  input  logic [5:0]               wb_opcode,
  input  logic [5:0]               wb_funct,
  input  logic [31:0]              wb_pc,
  input  logic [31:0]              wb_wd,
  input  logic [2:0]               sel,
  output logic [CW-1:0]            cnt_out,
  output logic [CW-1:0]            cycle_cnt,
  output logic [CW-1:0]            retired_cnt,
  output logic                     running,
  output logic                     done,
  output logic                     trc_valid,
  input  logic                     trc_rd_en,
  output logic [31:0]              trc_pc,
  output logic [2:0]               trc_class,
  output logic [31:0]              trc_wd,
  output logic [$clog2(DEPTH):0]   trc_level,
  output logic                     overflow,
  output logic [1:0]               dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] LIMIT_M1 = CW'(CYCLE_LIMIT - 1);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

  localparam logic [2:0] C_ALU    = 3'd0;
  localparam logic [2:0] C_MULDIV = 3'd1;
  localparam logic [2:0] C_LW     = 3'd2;
  localparam logic [2:0] C_SW     = 3'd3;
  localparam logic [2:0] C_BRANCH = 3'd4;
  localparam logic [2:0] C_JUMP   = 3'd5;
  localparam logic [2:0] C_ORI    = 3'd6;
  localparam logic [2:0] C_OTHER  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [CW-1:0] r_cycle_cnt;
  logic [CW-1:0] r_retired_cnt;
  logic [CW-1:0] r_class_cnt [8];

  logic [31:0]   r_mem_pc    [DEPTH];
  logic [2:0]    r_mem_class [DEPTH];
  logic [31:0]   r_mem_wd    [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_overflow;

  logic [2:0] w_class;
  logic       w_run;
  logic       w_limit_hit;
  logic       w_push_req;
  logic       w_full;
  logic       w_empty;
  logic       w_pop;
  logic       w_push;
  logic       w_drop;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Instruction classifier
  always_comb begin
    w_class = C_OTHER;
    case (wb_opcode)
      6'd0: begin
        case (wb_funct)
          6'd32, 6'd34, 6'd36, 6'd37, 6'd0, 6'd42: w_class = C_ALU;
          6'd27, 6'd16, 6'd18:                     w_class = C_MULDIV;
          default:                                 w_class = C_OTHER;
        endcase
      end
      6'd35:       w_class = C_LW;
      6'd43:       w_class = C_SW;
      6'd4, 6'd5:  w_class = C_BRANCH;
      6'd2:        w_class = C_JUMP;
      6'd13:       w_class = C_ORI;
      default:     w_class = C_OTHER;
    endcase
  end

  assign w_run       = (r_state == S_RUN);
  assign w_limit_hit = (CYCLE_LIMIT != 0) && (r_cycle_cnt == LIMIT_M1);

  always_comb begin
    w_next_state = r_state;
    if (clr) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_next_state = S_RUN;
        S_RUN:   if (w_limit_hit) w_next_state = S_DONE;
        S_DONE:  w_next_state = S_DONE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle_cnt   <= '0;
      r_retired_cnt <= '0;
      for (int i = 0; i < 8; i++) r_class_cnt[i] <= '0;
    end else if (clr) begin
      r_cycle_cnt   <= '0;
      r_retired_cnt <= '0;
      for (int i = 0; i < 8; i++) r_class_cnt[i] <= '0;
    end else if (w_run) begin
      r_cycle_cnt <= sat_inc(r_cycle_cnt);
      if (wb_valid) begin
        r_retired_cnt        <= sat_inc(r_retired_cnt);
        r_class_cnt[w_class] <= sat_inc(r_class_cnt[w_class]);
      end
    end
  end

  // A push into a full FIFO survives only when the head is popped on the same edge.
  assign w_empty    = (r_level == '0);
  assign w_full     = (r_level == FULL_LVL);
  assign w_push_req = w_run && wb_valid && !clr;
  assign w_pop      = trc_rd_en && !w_empty && !clr;
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]    <= wb_pc;
      r_mem_class[r_wr_ptr] <= w_class;
      r_mem_wd[r_wr_ptr]    <= wb_wd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else if (clr) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign cnt_out     = r_class_cnt[sel];
  assign cycle_cnt   = r_cycle_cnt;
  assign retired_cnt = r_retired_cnt;
  assign running     = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign dbg_state   = r_state;

  // Head fields are masked so stale memory never shows while empty.
  assign trc_valid = !w_empty;
  assign trc_pc    = w_empty ? 32'd0 : r_mem_pc[r_rd_ptr];
  assign trc_class = w_empty ? 3'd0  : r_mem_class[r_rd_ptr];
  assign trc_wd    = w_empty ? 32'd0 : r_mem_wd[r_rd_ptr];
  assign trc_level = r_level;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_wb_retire_monitor.sv
// Directed bench for wb_retire_monitor: trace records are checked by a
// scoreboard monitor; counters and flags are checked against hand values.
module tb_wb_retire_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, clr, wb_valid, trc_rd_en;
  logic [5:0]  wb_opcode, wb_funct;
  logic [31:0] wb_pc, wb_wd;
  logic [2:0]  sel;

  logic [31:0] cnt_out, cycle_cnt, retired_cnt;
  logic        running, done, trc_valid, overflow;
  logic [31:0] trc_pc, trc_wd;
  logic [2:0]  trc_class;
  logic [3:0]  trc_level;
  logic [1:0]  dbg_state;

  logic [3:0]  s_cnt_out, s_cycle_cnt, s_retired_cnt;
  logic        s_running, s_done, s_trc_valid, s_overflow;
  logic [31:0] s_trc_pc, s_trc_wd;
  logic [2:0]  s_trc_class;
  logic [3:0]  s_trc_level;
  logic [1:0]  s_dbg_state;

  logic [66:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_retire_monitor #(.CW(32), .DEPTH(8), .CYCLE_LIMIT(32)) u_dut (
    .clk(clk), .rst(rst), .start(start), .clr(clr), .wb_valid(wb_valid),
    .wb_opcode(wb_opcode), .wb_funct(wb_funct), .wb_pc(wb_pc), .wb_wd(wb_wd),
    .sel(sel), .cnt_out(cnt_out), .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt),
    .running(running), .done(done), .trc_valid(trc_valid), .trc_rd_en(trc_rd_en),
    .trc_pc(trc_pc), .trc_class(trc_class), .trc_wd(trc_wd), .trc_level(trc_level),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  wb_retire_monitor #(.CW(4), .DEPTH(8), .CYCLE_LIMIT(0)) u_sat (
    .clk(clk), .rst(rst), .start(start), .clr(clr), .wb_valid(wb_valid),
    .wb_opcode(wb_opcode), .wb_funct(wb_funct), .wb_pc(wb_pc), .wb_wd(wb_wd),
    .sel(sel), .cnt_out(s_cnt_out), .cycle_cnt(s_cycle_cnt), .retired_cnt(s_retired_cnt),
    .running(s_running), .done(s_done), .trc_valid(s_trc_valid), .trc_rd_en(trc_rd_en),
    .trc_pc(s_trc_pc), .trc_class(s_trc_class), .trc_wd(s_trc_wd), .trc_level(s_trc_level),
    .overflow(s_overflow), .dbg_state(s_dbg_state)
  );

  // Scoreboard monitor: every head record consumed by a pop is compared.
  always @(negedge clk) begin
    logic [66:0] e;
    if (rst && trc_valid && trc_rd_en) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL trc_unexpected: got pc=%h class=%0d wd=%h, required no record",
                 trc_pc, trc_class, trc_wd);
      end else begin
        e = exp_q.pop_front();
        if ({trc_pc, trc_class, trc_wd} !== e) begin
          n_bad++;
          $display("FAIL trc_record: got pc=%h class=%0d wd=%h, required pc=%h class=%0d wd=%h",
                   trc_pc, trc_class, trc_wd, e[66:35], e[34:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%h), required %0d (0x%h)", nm, act, act, exp, exp);
    end
  endtask

  // Inputs are applied 1 time unit after a rising edge and take effect on the next one.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] pc,
                        input logic [31:0] wd, input logic [2:0] cls, input bit rd,
                        input bit expect_push);
    wb_valid  = 1'b1;
    wb_opcode = op;
    wb_funct  = fn;
    wb_pc     = pc;
    wb_wd     = wd;
    trc_rd_en = rd;
    if (expect_push) exp_q.push_back({pc, cls, wd});
    tick();
    wb_valid  = 1'b0;
    trc_rd_en = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      trc_rd_en = 1'b1;
      tick();
    end
    trc_rd_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_q.delete();
  endtask

  task automatic read_cnt(input logic [2:0] s, input logic [31:0] exp, input string nm);
    sel = s;
    @(negedge clk);
    chk(nm, cnt_out, exp);
    tick();
    sel = 3'd0;
  endtask

  logic [5:0] mx_op  [18] = '{6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd13, 6'd0, 6'd0, 6'd0,
                              6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd63, 6'd1};
  logic [5:0] mx_fn  [18] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd27, 6'd18, 6'd35,
                              6'd32, 6'd34, 6'd36, 6'd37, 6'd0, 6'd42, 6'd16, 6'd0, 6'd0};
  logic [2:0] mx_cls [18] = '{3'd2, 3'd3, 3'd4, 3'd4, 3'd5, 3'd6, 3'd1, 3'd1, 3'd7,
                              3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd7, 3'd7};
  logic [31:0] mx_exp [8] = '{32'd6, 32'd3, 32'd1, 32'd1, 32'd2, 32'd1, 32'd1, 32'd3};
  logic [31:0] sp_exp [8] = '{32'd0, 32'd2, 32'd1, 32'd1, 32'd2, 32'd1, 32'd1, 32'd1};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; start = 1'b0; clr = 1'b0; wb_valid = 1'b0; trc_rd_en = 1'b0;
    wb_opcode = '0; wb_funct = '0; wb_pc = '0; wb_wd = '0; sel = '0;

    // Reset values
    #3;
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_trc_valid", {31'd0, trc_valid}, 32'd0);
    chk("rst_level", {28'd0, trc_level}, 32'd0);
    chk("rst_cycle", cycle_cnt, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_trc_pc", trc_pc, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // Five ALU retires, then drain through the scoreboard
    pulse_start();
    chk("t1_running", {31'd0, running}, 32'd1);
    for (int i = 0; i < 5; i++)
      retire(6'd0, 6'd32, 32'h100 + 32'(4 * i), 32'(3 * i + 7), 3'd0, 1'b0, 1'b1);
    chk("t1_alu", cnt_out, 32'd5);
    chk("t1_retired", retired_cnt, 32'd5);
    chk("t1_level", {28'd0, trc_level}, 32'd5);
    chk("t1_head_pc", trc_pc, 32'h100);
    chk("t1_cycle", cycle_cnt, 32'd5);
    drain(5);
    chk("t1_level_drained", {28'd0, trc_level}, 32'd0);

    // Cycle limit with continuous NOPs, popping as records arrive
    do_clr();
    pulse_start();
    for (int i = 0; i < 31; i++)
      retire(6'd63, 6'd0, 32'h400 + 32'(4 * i), 32'(i), 3'd7, 1'b1, 1'b1);
    chk("t2_running_31", {31'd0, running}, 32'd1);
    chk("t2_cycle_31", cycle_cnt, 32'd31);
    retire(6'd63, 6'd0, 32'h47c, 32'd31, 3'd7, 1'b1, 1'b1);
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_running", {31'd0, running}, 32'd0);
    chk("t2_cycle", cycle_cnt, 32'd32);
    chk("t2_retired", retired_cnt, 32'd32);
    chk("t2_level", {28'd0, trc_level}, 32'd1);
    for (int i = 0; i < 3; i++)
      retire(6'd63, 6'd0, 32'h900, 32'd0, 3'd7, 1'b0, 1'b0);
    pulse_start();
    chk("t2_done_hold", {31'd0, done}, 32'd1);
    chk("t2_cycle_frozen", cycle_cnt, 32'd32);
    read_cnt(3'd7, 32'd32, "t2_other_frozen");
    drain(1);
    chk("t2_level_drained", {28'd0, trc_level}, 32'd0);

    // Overflow: ten pushes into eight entries, then push+pop while full
    do_clr();
    pulse_start();
    for (int i = 0; i < 10; i++)
      retire(6'd0, 6'd34, 32'h200 + 32'(4 * i), 32'hA0 + 32'(i), 3'd0, 1'b0, i < 8);
    chk("t3_level_full", {28'd0, trc_level}, 32'd8);
    chk("t3_overflow", {31'd0, overflow}, 32'd1);
    chk("t3_head_pc", trc_pc, 32'h200);
    retire(6'd13, 6'd0, 32'h300, 32'hBEEF, 3'd6, 1'b1, 1'b1);
    chk("t3_level_pushpop", {28'd0, trc_level}, 32'd8);
    chk("t3_head_pc2", trc_pc, 32'h204);
    chk("t3_overflow_sticky", {31'd0, overflow}, 32'd1);
    drain(8);
    chk("t3_empty", {31'd0, trc_valid}, 32'd0);
    chk("t3_empty_pc", trc_pc, 32'd0);

    // Mixed stream: first nine instructions, then the remaining functs
    do_clr();
    pulse_start();
    for (int i = 0; i < 9; i++)
      retire(mx_op[i], mx_fn[i], 32'h600 + 32'(4 * i), 32'h1000 + 32'(i), mx_cls[i], 1'b1, 1'b1);
    for (int c = 0; c < 8; c++)
      read_cnt(3'(c), sp_exp[c], $sformatf("t4_class%0d", c));
    for (int i = 9; i < 18; i++)
      retire(mx_op[i], mx_fn[i], 32'h600 + 32'(4 * i), 32'h1000 + 32'(i), mx_cls[i], 1'b1, 1'b1);
    drain(1);
    chk("t4_retired", retired_cnt, 32'd18);
    for (int c = 0; c < 8; c++)
      read_cnt(3'(c), mx_exp[c], $sformatf("t4b_class%0d", c));

    // clr wins over start/wb_valid in the same cycle
    do_clr();
    pulse_start();
    retire(6'd35, 6'd0, 32'h700, 32'd1, 3'd2, 1'b0, 1'b1);
    clr = 1'b1; start = 1'b1; wb_valid = 1'b1; wb_opcode = 6'd35;
    tick();
    clr = 1'b0; start = 1'b0; wb_valid = 1'b0;
    exp_q.delete();
    chk("t5_running", {31'd0, running}, 32'd0);
    chk("t5_done", {31'd0, done}, 32'd0);
    chk("t5_retired", retired_cnt, 32'd0);
    chk("t5_cycle", cycle_cnt, 32'd0);
    chk("t5_level", {28'd0, trc_level}, 32'd0);
    chk("t5_lw", cnt_out, 32'd0);
    pulse_start();
    chk("t5_restart", {31'd0, running}, 32'd1);

    // Async reset mid-run, away from the clock edge
    retire(6'd0, 6'd32, 32'h800, 32'd2, 3'd0, 1'b0, 1'b0);
    retire(6'd0, 6'd32, 32'h804, 32'd3, 3'd0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("t6_running", {31'd0, running}, 32'd0);
    chk("t6_retired", retired_cnt, 32'd0);
    chk("t6_cycle", cycle_cnt, 32'd0);
    chk("t6_trc_valid", {31'd0, trc_valid}, 32'd0);
    chk("t6_level", {28'd0, trc_level}, 32'd0);
    chk("t6_alu", cnt_out, 32'd0);
    exp_q.delete();
    #1 rst = 1'b1;
    tick();

    // CW=4 saturation on the second instance
    do_clr();
    pulse_start();
    for (int i = 0; i < 20; i++)
      retire(6'd0, 6'd32, 32'hC00 + 32'(4 * i), 32'(i), 3'd0, 1'b1, 1'b1);
    drain(1);
    chk("t7_sat_alu", {28'd0, s_cnt_out}, 32'd15);
    chk("t7_sat_retired", {28'd0, s_retired_cnt}, 32'd15);
    chk("t7_sat_cycle", {28'd0, s_cycle_cnt}, 32'd15);
    chk("t7_sat_running", {31'd0, s_running}, 32'd1);
    chk("t7_wide_alu", cnt_out, 32'd20);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
